// File: rtl/fx_match_if.sv
// Requester/resource bundle for the shared FxMatch scheduler.
// Slave is the scheduler; master is the requester/resource side.
interface fx_match_if #(
  parameter int NREQ = 4,
  parameter int IW   = 12,
  parameter int OW   = 13,
  parameter int LAT  = 1
);
  localparam int CW = $clog2(LAT + 2);

  logic                 issue_en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [IW-1:0]        fx_i_data;
  logic [OW-1:0]        fx_o_data;
  logic [NREQ-1:0]      res_valid;
  logic [OW-1:0]        res_data;
  logic [CW-1:0]        inflight;
  logic                 idle;

  modport slave (
    input  issue_en, req_valid, req_data, fx_o_data,
    output req_ready, fx_i_data, res_valid, res_data,
    output inflight, idle
  );

  modport master (
    output issue_en, req_valid, req_data, fx_o_data,
    input  req_ready, fx_i_data, res_valid, res_data,
    input  inflight, idle
  );
endinterface

// File: rtl/fx_match_sched.sv
// Round-robin sharing of one pipelined FxMatch resource among NREQ
// requesters, with a tag pipeline routing each result back home.
module fx_match_sched #(
  parameter int NREQ = 4,
  parameter int IW   = 12,
  parameter int OW   = 13,
  parameter int LAT  = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  fx_match_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(LAT + 2);
  localparam int NS = LAT + 1;
  localparam int SW = PW + 1;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     fxi_q, fxi_d;
  logic [NS-1:0]     tv_q, tv_d;
  logic [PW-1:0]     tid_q [NS];
  logic [PW-1:0]     tid_d [NS];
  logic [NREQ-1:0]   rv_q, rv_d;
  logic [OW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     inf_q, inf_d;

  logic [2*NREQ-1:0] dbl;
  logic [PW-1:0]     off;
  logic [SW-1:0]     sum;
  logic [PW-1:0]     gid;
  logic              found;
  logic [NREQ-1:0]   grant;
  logic              hs;
  logic              ret;

  // Rotate the request vector so index 0 is the pointer position.
  always_comb begin
    dbl   = {bus.req_valid, bus.req_valid} >> ptr_q;
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        off   = PW'(i);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= SW'(NREQ))
      gid = PW'(sum - SW'(NREQ));
    else
      gid = PW'(sum);
    grant = '0;
    if (bus.issue_en && found)
      grant = NREQ'(1) << gid;
  end

  assign hs  = |grant;
  assign ret = tv_q[NS-1];

  always_comb begin
    ptr_d = ptr_q;
    fxi_d = fxi_q;
    if (hs) begin
      fxi_d = bus.req_data[gid*IW +: IW];
      if (gid == PW'(NREQ - 1))
        ptr_d = '0;
      else
        ptr_d = gid + 1'b1;
    end

    tv_d[0]  = hs;
    tid_d[0] = gid;
    for (int s = 1; s < NS; s++) begin
      tv_d[s]  = tv_q[s-1];
      tid_d[s] = tid_q[s-1];
    end

    rv_d = '0;
    rd_d = rd_q;
    if (ret) begin
      rv_d = NREQ'(1) << tid_q[NS-1];
      rd_d = bus.fx_o_data;
    end

    inf_d = inf_q;
    if (hs && !ret)
      inf_d = inf_q + 1'b1;
    else if (!hs && ret)
      inf_d = inf_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      fxi_q <= '0;
      tv_q  <= '0;
      for (int s = 0; s < NS; s++)
        tid_q[s] <= '0;
      rv_q  <= '0;
      rd_q  <= '0;
      inf_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      fxi_q <= fxi_d;
      tv_q  <= tv_d;
      for (int s = 0; s < NS; s++)
        tid_q[s] <= tid_d[s];
      rv_q  <= rv_d;
      rd_q  <= rd_d;
      inf_q <= inf_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.fx_i_data = fxi_q;
  assign bus.res_valid = rv_q;
  assign bus.res_data  = rd_q;
  assign bus.inflight  = inf_q;
  assign bus.idle      = (inf_q == '0) && !hs;

  a_res_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(rv_q)
  );
endmodule

// File: tb/tb_fx_match_sched.sv
// Directed bench for fx_match_sched with a sign-extending
// one-register FxMatch resource model (12 -> 13 bits).
module tb_fx_match_sched;
  localparam int NREQ = 4;
  localparam int IW   = 12;
  localparam int OW   = 13;
  localparam int LAT  = 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [IW-1:0] d [NREQ];

  fx_match_if #(
    .NREQ(NREQ), .IW(IW), .OW(OW), .LAT(LAT)
  ) bus ();

  fx_match_sched #(
    .NREQ(NREQ), .IW(IW), .OW(OW), .LAT(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    bus.fx_o_data <= {bus.fx_i_data[IW-1], bus.fx_i_data};

  function automatic logic [OW-1:0] sext(input logic [IW-1:0] v);
    return {v[IW-1], v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int k, input logic [IW-1:0] v);
    bus.req_data[k*IW +: IW] = v;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.issue_en  = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    #12;
    chk("rst_ready",    32'(bus.req_ready), 32'h0);
    chk("rst_fxi",      32'(bus.fx_i_data), 32'h0);
    chk("rst_resv",     32'(bus.res_valid), 32'h0);
    chk("rst_resd",     32'(bus.res_data),  32'h0);
    chk("rst_inflight", 32'(bus.inflight),  32'h0);
    chk("rst_idle",     32'(bus.idle),      32'h1);
    rst_n = 1'b1;

    // single request on requester 0
    bus.issue_en  = 1'b1;
    set_data(0, 12'h7FF);
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    chk("single_fxi",  32'(bus.fx_i_data), 32'h7FF);
    chk("single_inf1", 32'(bus.inflight),  32'h1);
    chk("single_rv0",  32'(bus.res_valid), 32'h0);
    tick();
    chk("single_rv1",  32'(bus.res_valid), 32'h0);
    chk("single_inf2", 32'(bus.inflight),  32'h1);
    tick();
    chk("single_rv",   32'(bus.res_valid), 32'h1);
    chk("single_rd",   32'(bus.res_data),  32'h07FF);
    chk("single_inf3", 32'(bus.inflight),  32'h0);
    chk("single_idle", 32'(bus.idle),      32'h1);
    tick();
    chk("single_rv_once", 32'(bus.res_valid), 32'h0);

    // negative sample on requester 2 (ptr=1)
    set_data(2, 12'h800);
    bus.req_valid = 4'b0100;
    #1;
    chk("neg_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("neg_rv", 32'(bus.res_valid), 32'h4);
    chk("neg_rd", 32'(bus.res_data),  32'h1800);

    // requester 3 wraps pointer back to 0
    set_data(3, 12'h123);
    bus.req_valid = 4'b1000;
    #1;
    chk("wrap_ready", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("wrap_rv", 32'(bus.res_valid), 32'h8);
    chk("wrap_rd", 32'(bus.res_data),  32'h0123);
    tick();

    // all valid, back-to-back
    d[0] = 12'h0A5;
    d[1] = 12'h35A;
    d[2] = 12'h7C0;
    d[3] = 12'hC03;
    for (int k = 0; k < NREQ; k++)
      set_data(k, d[k]);
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("b2b_ready", 32'(bus.req_ready), 32'(1 << (i % 4)));
      tick();
      if (i >= 2) begin
        chk("b2b_rv", 32'(bus.res_valid), 32'(1 << ((i - 2) % 4)));
        chk("b2b_rd", 32'(bus.res_data),  32'(sext(d[(i - 2) % 4])));
      end
      chk("b2b_inf", 32'(bus.inflight), (i == 0) ? 32'h1 : 32'h2);
    end

    // fairness: grant 1 sets ptr=2, then 1011 held
    bus.req_valid = 4'b0010;
    #1;
    chk("fair_g1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b1011;
    #1;
    chk("fair_a", 32'(bus.req_ready), 32'h8);
    tick();
    chk("fair_b", 32'(bus.req_ready), 32'h1);
    tick();
    chk("fair_c", 32'(bus.req_ready), 32'h2);
    tick();
    chk("fair_d", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0001;
    #1;
    chk("fair_e", 32'(bus.req_ready), 32'h1);
    tick();

    // drain with issue_en low (ptr=1)
    bus.issue_en  = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    chk("drain_ready", 32'(bus.req_ready), 32'h0);
    chk("drain_inf2",  32'(bus.inflight),  32'h2);
    tick();
    chk("drain_rv1",   32'(bus.res_valid), 32'h8);
    chk("drain_rd1",   32'(bus.res_data),  32'(sext(d[3])));
    chk("drain_inf1",  32'(bus.inflight),  32'h1);
    tick();
    chk("drain_rv2",   32'(bus.res_valid), 32'h1);
    chk("drain_rd2",   32'(bus.res_data),  32'(sext(d[0])));
    chk("drain_inf0",  32'(bus.inflight),  32'h0);
    chk("drain_idle",  32'(bus.idle),      32'h1);
    tick();
    chk("drain_rv3",   32'(bus.res_valid), 32'h0);
    chk("drain_hold",  32'(bus.req_ready), 32'h0);

    // re-enable resumes from unchanged pointer
    bus.issue_en = 1'b1;
    #1;
    chk("reen_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    chk("reen_ready2", 32'(bus.req_ready), 32'h4);
    tick();
    chk("reen_ready3", 32'(bus.req_ready), 32'h8);
    tick();
    chk("reen_rv", 32'(bus.res_valid), 32'h2);
    bus.req_valid = '0;

    // reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_rv",   32'(bus.res_valid), 32'h0);
    chk("mrst_rd",   32'(bus.res_data),  32'h0);
    chk("mrst_inf",  32'(bus.inflight),  32'h0);
    chk("mrst_fxi",  32'(bus.fx_i_data), 32'h0);
    chk("mrst_idle", 32'(bus.idle),      32'h1);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rv", 32'(bus.res_valid), 32'h0);
    end
    chk("post_inf", 32'(bus.inflight), 32'h0);
    bus.req_valid = 4'b1111;
    #1;
    chk("post_grant", 32'(bus.req_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
